jtopl_pm: RTL and testbench

- Per-slot vibrato (phase-modulation) consumer of the 3-bit LFO vibrato counter.
- Takes each slot's F-number and block, adds the signed vibrato offset selected by the LFO position and depth bit, and produces the phase increment used by the phase generator.
- Sits between the register/slot multiplexer and the phase accumulator.
- Processes one slot per cenop, fully pipelined.

---
 rtl/jtopl_pm_pkg.sv | 40 ++++
 rtl/jtopl_pm_if.sv | 28 ++
 rtl/jtopl_pm_delta.sv | 38 +++
 rtl/jtopl_pm.sv | 111 +++++++++++
 tb/tb_jtopl_pm.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/jtopl_pm_pkg.sv
// jtopl_pm_pkg: shared constants for the vibrato phase-modulation block.
//   FMODW / BASEW : widths of the modulated F-number and the shifted base
//   vib_mag_e     : offset magnitude class (zero / half range / full range)
//   vib_shape()   : LFO position -> {sign, magnitude class}
//   MUL_TBL       : frequency multiplier per mult code (code 0 stands for 1/2)
package jtopl_pm_pkg;

    localparam int FMODW = 11;
    localparam int BASEW = 17;

    typedef enum logic [1:0] {
        VIB_ZERO = 2'd0,
        VIB_HALF = 2'd1,
        VIB_FULL = 2'd2
    } vib_mag_e;

    typedef struct packed {
        logic     neg;
        vib_mag_e mag;
    } vib_shape_t;

    // Triangle-like vibrato: 0, +h, +f, +h, 0, -h, -f, -h
    function automatic vib_shape_t vib_shape(input logic [2:0] pos);
        vib_shape_t s;
        s.neg = pos[2];
        case (pos[1:0])
            2'd0:    s.mag = VIB_ZERO;
            2'd2:    s.mag = VIB_FULL;
            default: s.mag = VIB_HALF;
        endcase
        return s;
    endfunction

    // Entry 0 is unused: code 0 means x1/2, applied as a right shift.
    localparam logic [15:0][3:0] MUL_TBL = {
        4'd15, 4'd15, 4'd12, 4'd12, 4'd10, 4'd10, 4'd9, 4'd8,
        4'd7,  4'd6,  4'd5,  4'd4,  4'd3,  4'd2,  4'd1, 4'd0
    };

endpackage

// File: rtl/jtopl_pm_if.sv
// jtopl_pm_if: slot bus between the slot multiplexer and the vibrato block.
//   cenop, vib_cnt, dvb, viben, fnum, block, mult : slot inputs (master drives)
//   pinc, fmod                                    : results (slave drives)
interface jtopl_pm_if
    import jtopl_pm_pkg::*;
#(
    parameter int PW = 20
);
    logic             cenop;
    logic [2:0]       vib_cnt;
    logic             dvb;
    logic             viben;
    logic [9:0]       fnum;
    logic [2:0]       block;
    logic [3:0]       mult;
    logic [PW-1:0]    pinc;
    logic [FMODW-1:0] fmod;

    modport master (
        output cenop, vib_cnt, dvb, viben, fnum, block, mult,
        input  pinc, fmod
    );

    modport slave (
        input  cenop, vib_cnt, dvb, viben, fnum, block, mult,
        output pinc, fmod
    );
endinterface

// File: rtl/jtopl_pm_delta.sv
// jtopl_pm_delta: combinational signed vibrato offset for one slot.
//   fnum_hi : fnum[9:7], sets the offset range
//   vib_cnt : LFO vibrato position 0..7
//   dvb     : 1 = deep, 0 = shallow (range halved)
//   viben   : 0 forces the offset to zero
//   delta   : signed offset, -7..+7
module jtopl_pm_delta
    import jtopl_pm_pkg::*;
(
    input  logic [2:0]        fnum_hi,
    input  logic [2:0]        vib_cnt,
    input  logic              dvb,
    input  logic              viben,
    output logic signed [3:0] delta
);
    vib_shape_t        shape;
    logic [2:0]        range;
    logic [2:0]        mag;
    logic signed [3:0] mag_s;

    always_comb begin
        shape = vib_shape(vib_cnt);
        range = dvb ? fnum_hi : (fnum_hi >> 1);
        case (shape.mag)
            VIB_FULL: mag = range;
            VIB_HALF: mag = range >> 1;
            default:  mag = 3'd0;
        endcase
        mag_s = signed'({1'b0, mag});
        if (!viben) begin
            delta = 4'sd0;
        end else if (shape.neg) begin
            delta = -mag_s;
        end else begin
            delta = mag_s;
        end
    end
endmodule

// File: rtl/jtopl_pm.sv
// jtopl_pm: per-slot vibrato phase modulation, one slot per cenop.
//   clk, rst : clock and synchronous active-high reset
//   bus      : jtopl_pm_if.slave carrying the slot inputs and pinc / fmod
// Stage 1 registers fmod = fnum + vibrato offset; stage 2 registers
// base = (fmod << block) >> 1. With JTOPL_PM_MULT_EN defined, stage 3
// registers pinc = base * MUL(mult); otherwise pinc = base and mult is unused.
// PW must be at least 20 so the x15 product fits.
module jtopl_pm
    import jtopl_pm_pkg::*;
#(
    parameter int PW = 20
)(
    input  logic        clk,
    input  logic        rst,
    jtopl_pm_if.slave   bus
);
    logic signed [3:0]       delta_p0;
    logic signed [FMODW-1:0] fnum_s_p0;
    logic signed [FMODW-1:0] delta_x_p0;
    logic signed [FMODW-1:0] fmod_s_p0;

    logic [FMODW-1:0] fmod_p1;
    logic [2:0]       block_p1;
    logic [BASEW:0]   shl_p1;
    logic [BASEW-1:0] base_p1;

    logic [BASEW-1:0] base_p2;

    jtopl_pm_delta u_delta (
        .fnum_hi (bus.fnum[9:7]),
        .vib_cnt (bus.vib_cnt),
        .dvb     (bus.dvb),
        .viben   (bus.viben),
        .delta   (delta_p0)
    );

    // Offset never exceeds fnum[9:7], so the sum stays non-negative.
    assign fnum_s_p0  = signed'({1'b0, bus.fnum});
    assign delta_x_p0 = {{(FMODW-4){delta_p0[3]}}, delta_p0};
    assign fmod_s_p0  = fnum_s_p0 + delta_x_p0;

    // ---- stage 1: modulated F-number ----
    always_ff @(posedge clk) begin
        if (rst) begin
            fmod_p1  <= '0;
            block_p1 <= '0;
        end else if (bus.cenop) begin
            fmod_p1  <= fmod_s_p0;
            block_p1 <= bus.block;
        end
    end

    assign shl_p1  = {{(BASEW+1-FMODW){1'b0}}, fmod_p1} << block_p1;
    assign base_p1 = shl_p1[BASEW:1];

    // ---- stage 2: octave-shifted base increment ----
    always_ff @(posedge clk) begin
        if (rst) begin
            base_p2 <= '0;
        end else if (bus.cenop) begin
            base_p2 <= base_p1;
        end
    end

    assign bus.fmod = fmod_p1;

`ifdef JTOPL_PM_MULT_EN
    logic [3:0]    mult_p1;
    logic [3:0]    mult_p2;
    logic [PW-1:0] pinc_p3;

    function automatic logic [PW-1:0] mul_apply(input logic [BASEW-1:0] base,
                                                input logic [3:0]       code);
        logic [BASEW+3:0] prod;
        if (code == 4'd0) begin
            prod = {4'd0, base >> 1};
        end else begin
            prod = {4'd0, base} * {{BASEW{1'b0}}, MUL_TBL[code]};
        end
        return PW'(prod);
    endfunction

    // mult rides along with fmod/base so it meets its own slot in stage 3.
    always_ff @(posedge clk) begin
        if (rst) begin
            mult_p1 <= '0;
            mult_p2 <= '0;
        end else if (bus.cenop) begin
            mult_p1 <= bus.mult;
            mult_p2 <= mult_p1;
        end
    end

    // ---- stage 3: frequency multiplier ----
    always_ff @(posedge clk) begin
        if (rst) begin
            pinc_p3 <= '0;
        end else if (bus.cenop) begin
            pinc_p3 <= mul_apply(base_p2, mult_p2);
        end
    end

    assign bus.pinc = pinc_p3;
`else
    logic unused_mult;

    assign unused_mult = ^bus.mult;
    assign bus.pinc    = PW'(base_p2);
`endif

endmodule

// File: tb/tb_jtopl_pm.sv
// tb_jtopl_pm: directed bench for jtopl_pm (default build or JTOPL_PM_MULT_EN).
// Expected pinc values wait in a queue sized to the pipeline latency, so each
// slot's pinc is compared exactly at the strobe where it must appear.
module tb_jtopl_pm;
    localparam int PW = 20;
`ifdef JTOPL_PM_MULT_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic clk = 1'b0;
    logic rst;

    jtopl_pm_if #(.PW(PW)) bus ();

    jtopl_pm #(.PW(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int unsigned exp_q[$];
    int unsigned last_pinc;
    int unsigned last_fmod;

    int unsigned deep_f[8]  = '{1023, 1026, 1030, 1026, 1023, 1020, 1016, 1020};
    int unsigned deep_p[8]  = '{511, 513, 515, 513, 511, 510, 508, 510};
    int unsigned shal_f[8]  = '{1023, 1024, 1026, 1024, 1023, 1022, 1020, 1022};
    int unsigned shal_p[8]  = '{511, 512, 513, 512, 511, 511, 510, 511};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic [9:0] fnum, input logic [2:0] block,
                          input logic dvb, input logic viben,
                          input logic [2:0] vib, input logic [3:0] mult);
        bus.fnum    = fnum;
        bus.block   = block;
        bus.dvb     = dvb;
        bus.viben   = viben;
        bus.vib_cnt = vib;
        bus.mult    = mult;
    endtask

    task automatic strobe();
        @(negedge clk);
        bus.cenop = 1'b1;
        @(posedge clk);
        #1;
        bus.cenop = 1'b0;
    endtask

    task automatic slot(input string tag, input logic [9:0] fnum, input logic [2:0] block,
                        input logic dvb, input logic viben, input logic [2:0] vib,
                        input logic [3:0] mult, input int unsigned exp_fmod,
                        input int unsigned exp_pinc);
        set_in(fnum, block, dvb, viben, vib, mult);
        exp_q.push_back(exp_pinc);
        strobe();
        chk({tag, ".fmod"}, 32'(bus.fmod), exp_fmod);
        last_fmod = exp_fmod;
        if (exp_q.size() == LAT) begin
            last_pinc = exp_q.pop_front();
            chk({tag, ".pinc"}, 32'(bus.pinc), last_pinc);
        end
    endtask

    // Inputs churn with cenop low; outputs must not move.
    task automatic hold(input string tag, input int n);
        set_in(10'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
               3'($urandom), 4'($urandom));
        repeat (n) @(posedge clk);
        #1;
        chk({tag, ".hold_fmod"}, 32'(bus.fmod), last_fmod);
        chk({tag, ".hold_pinc"}, 32'(bus.pinc), last_pinc);
    endtask

    task automatic do_reset(input string tag);
        set_in(10'h3FF, 3'd7, 1'b1, 1'b1, 3'd2, 4'd15);
        bus.cenop = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.cenop = 1'b0;
        chk({tag, ".rst_fmod"}, 32'(bus.fmod), 0);
        chk({tag, ".rst_pinc"}, 32'(bus.pinc), 0);
        exp_q.delete();
        for (int k = 0; k < LAT - 1; k++) exp_q.push_back(0);
        last_pinc = 0;
        last_fmod = 0;
    endtask

    task automatic flush();
        for (int k = 0; k < LAT - 1; k++)
            slot($sformatf("flush%0d", k), 10'd0, 3'd0, 1'b1, 1'b1, 3'd0, 4'd1, 0, 0);
    endtask

    initial begin
        rst = 1'b0;
        bus.cenop = 1'b0;
        set_in(10'd0, 3'd0, 1'b0, 1'b0, 3'd0, 4'd1);
        do_reset("init");

        for (int i = 0; i < 8; i++) begin
            slot($sformatf("deep%0d", i), 10'h3FF, 3'd0, 1'b1, 1'b1, 3'(i), 4'd1,
                 deep_f[i], deep_p[i]);
            hold($sformatf("deep%0d", i), 3);
        end
        for (int i = 0; i < 8; i++)
            slot($sformatf("shal%0d", i), 10'h3FF, 3'd0, 1'b0, 1'b1, 3'(i), 4'd1,
                 shal_f[i], shal_p[i]);

        slot("viben0_b0", 10'h200, 3'd0, 1'b1, 1'b0, 3'd2, 4'd1, 512, 256);
        slot("viben0_b7", 10'h200, 3'd7, 1'b1, 1'b0, 3'd2, 4'd1, 512, 32768);

        for (int i = 0; i < 8; i++)
            slot($sformatf("fnum0_%0d", i), 10'd0, 3'd7, 1'b1, 1'b1, 3'(i), 4'd1, 0, 0);

        slot("max", 10'h3FF, 3'd7, 1'b1, 1'b1, 3'd2, 4'd1, 1030, 65920);

`ifdef JTOPL_PM_MULT_EN
        slot("mult0",  10'h100, 3'd1, 1'b1, 1'b0, 3'd2, 4'd0,  256, 128);
        slot("mult11", 10'h100, 3'd1, 1'b1, 1'b0, 3'd2, 4'd11, 256, 2560);
        slot("mult15", 10'h100, 3'd1, 1'b1, 1'b0, 3'd2, 4'd15, 256, 3840);
        slot("maxm15", 10'h3FF, 3'd7, 1'b1, 1'b1, 3'd2, 4'd15, 1030, 988800);
`else
        slot("mult0",  10'h100, 3'd1, 1'b1, 1'b0, 3'd2, 4'd0,  256, 256);
        slot("mult11", 10'h100, 3'd1, 1'b1, 1'b0, 3'd2, 4'd11, 256, 256);
        slot("mult15", 10'h100, 3'd1, 1'b1, 1'b0, 3'd2, 4'd15, 256, 256);
        slot("maxm15", 10'h3FF, 3'd7, 1'b1, 1'b1, 3'd2, 4'd15, 1030, 65920);
`endif
        flush();

        // Two slots in flight, then reset; none of them may surface.
        slot("inflA", 10'h3FF, 3'd7, 1'b1, 1'b1, 3'd2, 4'd1, 1030, 65920);
        slot("inflB", 10'h200, 3'd7, 1'b1, 1'b0, 3'd0, 4'd1, 512, 32768);
        do_reset("mid");
        slot("postC", 10'h100, 3'd1, 1'b1, 1'b0, 3'd0, 4'd1, 256, 256);
        hold("postC", 3);
        flush();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
